// File: rtl/codec_slave_intf.sv
// Codec-side endpoint of the serial audio link: synchronizes the master's pins, deserializes
// left/right words from SDin and serializes the transmit pair onto SDout.
module codec_slave_intf #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LRCLK_i,
    input  logic              SCLK_i,
    input  logic              MCLK_i,
    input  logic              RSTn_i,
    input  logic              SDin_i,
    output logic              SDout_o,
    input  logic [DATA_W-1:0] lft_tx_i,
    input  logic [DATA_W-1:0] rht_tx_i,
    output logic              tx_load_o,
    output logic [DATA_W-1:0] lft_rx_o,
    output logic [DATA_W-1:0] rht_rx_o,
    output logic              rx_valid_o,
    output logic              frame_err_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    localparam logic [1:0] WAIT_RST = 2'd0;
    localparam logic [1:0] WAIT_LR  = 2'd1;
    localparam logic [1:0] LEFT     = 2'd2;
    localparam logic [1:0] RIGHT    = 2'd3;

    logic unused_mclk;
    assign unused_mclk = MCLK_i;

    logic [SYNC_STAGES-1:0] lrSync_q, sclkSync_q, rstSync_q, sdSync_q;
    logic lrHist_q, sclkHist_q, sdHist_q;
    logic lrRise_q, lrFall_q, sclkRise_q, sclkFall_q;
    logic rstnSync;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] txShift_q, txShift_d, txHold_q, txHold_d;
    logic [DATA_W-1:0] lftShift_q, lftShift_d, rhtShift_q, rhtShift_d;
    logic [DATA_W-1:0] lftRx_q, lftRx_d, rhtRx_q, rhtRx_d;
    logic              frameBad_q, frameBad_d, frameErr_q, frameErr_d;
    logic              txLoad_q, txLoad_d, rxValid_q, rxValid_d;
    logic              cntFull, lastBit;

    assign rstnSync = rstSync_q[SYNC_STAGES-1];

    // Edge strobes are registered, and SDin's history flop lines up with the SCLK strobe
    // so the bit used is the pin value from the cycle SCLK rose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrSync_q   <= '0;
            sclkSync_q <= '0;
            rstSync_q  <= '0;
            sdSync_q   <= '0;
            lrHist_q   <= 1'b0;
            sclkHist_q <= 1'b0;
            sdHist_q   <= 1'b0;
            lrRise_q   <= 1'b0;
            lrFall_q   <= 1'b0;
            sclkRise_q <= 1'b0;
            sclkFall_q <= 1'b0;
        end else begin
            lrSync_q   <= {lrSync_q[SYNC_STAGES-2:0], LRCLK_i};
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SCLK_i};
            rstSync_q  <= {rstSync_q[SYNC_STAGES-2:0], RSTn_i};
            sdSync_q   <= {sdSync_q[SYNC_STAGES-2:0], SDin_i};
            lrHist_q   <= lrSync_q[SYNC_STAGES-1];
            sclkHist_q <= sclkSync_q[SYNC_STAGES-1];
            sdHist_q   <= sdSync_q[SYNC_STAGES-1];
            lrRise_q   <= lrSync_q[SYNC_STAGES-1] & ~lrHist_q;
            lrFall_q   <= ~lrSync_q[SYNC_STAGES-1] & lrHist_q;
            sclkRise_q <= sclkSync_q[SYNC_STAGES-1] & ~sclkHist_q;
            sclkFall_q <= ~sclkSync_q[SYNC_STAGES-1] & sclkHist_q;
        end
    end

    assign cntFull = (cnt_q == CNT_MAX);
    assign lastBit = (cnt_q == CNT_MAX - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        txShift_d  = txShift_q;
        txHold_d   = txHold_q;
        lftShift_d = lftShift_q;
        rhtShift_d = rhtShift_q;
        lftRx_d    = lftRx_q;
        rhtRx_d    = rhtRx_q;
        frameBad_d = frameBad_q;
        frameErr_d = frameErr_q;
        txLoad_d   = 1'b0;
        rxValid_d  = 1'b0;

        if (!rstnSync) begin
            state_d   = WAIT_RST;
            txShift_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                WAIT_RST: begin
                    txShift_d = '0;
                    state_d   = WAIT_LR;
                end
                WAIT_LR: begin
                    if (lrRise_q) begin
                        state_d    = LEFT;
                        txLoad_d   = 1'b1;
                        txShift_d  = lft_tx_i;
                        txHold_d   = rht_tx_i;
                        cnt_d      = '0;
                        frameBad_d = 1'b0;
                    end
                end
                default: begin
                    // LRCLK edges win over a coincident SCLK edge.
                    if ((state_q == LEFT) && lrFall_q) begin
                        if (!cntFull) begin
                            frameErr_d = 1'b1;
                            frameBad_d = 1'b1;
                        end
                        state_d   = RIGHT;
                        txShift_d = txHold_q;
                        cnt_d     = '0;
                    end else if ((state_q == RIGHT) && lrRise_q) begin
                        if (!cntFull) begin
                            frameErr_d = 1'b1;
                        end
                        state_d    = LEFT;
                        txLoad_d   = 1'b1;
                        txShift_d  = lft_tx_i;
                        txHold_d   = rht_tx_i;
                        cnt_d      = '0;
                        frameBad_d = 1'b0;
                    end else if (sclkRise_q && !cntFull) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == LEFT) begin
                            lftShift_d = {lftShift_q[DATA_W-2:0], sdHist_q};
                        end else begin
                            rhtShift_d = {rhtShift_q[DATA_W-2:0], sdHist_q};
                        end
                        // Final bit of a half: blank SDout and publish a complete pair.
                        if (lastBit) begin
                            txShift_d = '0;
                            if ((state_q == RIGHT) && !frameBad_q) begin
                                rxValid_d = 1'b1;
                                lftRx_d   = lftShift_q;
                                rhtRx_d   = {rhtShift_q[DATA_W-2:0], sdHist_q};
                            end
                        end
                    end else if (sclkFall_q && !cntFull) begin
                        txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_RST;
            cnt_q      <= '0;
            txShift_q  <= '0;
            txHold_q   <= '0;
            lftShift_q <= '0;
            rhtShift_q <= '0;
            lftRx_q    <= '0;
            rhtRx_q    <= '0;
            frameBad_q <= 1'b0;
            frameErr_q <= 1'b0;
            txLoad_q   <= 1'b0;
            rxValid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            txShift_q  <= txShift_d;
            txHold_q   <= txHold_d;
            lftShift_q <= lftShift_d;
            rhtShift_q <= rhtShift_d;
            lftRx_q    <= lftRx_d;
            rhtRx_q    <= rhtRx_d;
            frameBad_q <= frameBad_d;
            frameErr_q <= frameErr_d;
            txLoad_q   <= txLoad_d;
            rxValid_q  <= rxValid_d;
        end
    end

    assign SDout_o     = txShift_q[DATA_W-1];
    assign tx_load_o   = txLoad_q;
    assign rx_valid_o  = rxValid_q;
    assign lft_rx_o    = lftRx_q;
    assign rht_rx_o    = rhtRx_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_codec_slave_intf.sv
// Bench for codec_slave_intf: plays master-timed frames, reads SDout back at SCLK rises and
// scoreboards received pairs against the words driven onto SDin.
module tb_codec_slave_intf;

    logic        clk;
    logic        rst_n;
    logic        LRCLK_i, SCLK_i, MCLK_i, RSTn_i, SDin_i;
    logic        SDout_o, tx_load_o, rx_valid_o, frame_err_o;
    logic [15:0] lft_tx_i, rht_tx_i, lft_rx_o, rht_rx_o;

    int passCount = 0;
    int checkCount = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [15:0] sdL, sdR, lftTx, rhtTx;
        logic [15:0] expRxL, expRxR, expTxL, expTxR;
    } vec_t;
    vec_t tbl[5];

    logic [15:0] txL, txR, dumL, dumR;
    int          tailBad, loads, dumTail, dumLoads;
    logic        dropSdout, dumDrop;
    logic [31:0] lastPair;

    codec_slave_intf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LRCLK_i    (LRCLK_i),
        .SCLK_i     (SCLK_i),
        .MCLK_i     (MCLK_i),
        .RSTn_i     (RSTn_i),
        .SDin_i     (SDin_i),
        .SDout_o    (SDout_o),
        .lft_tx_i   (lft_tx_i),
        .rht_tx_i   (rht_tx_i),
        .tx_load_o  (tx_load_o),
        .lft_rx_o   (lft_rx_o),
        .rht_rx_o   (rht_rx_o),
        .rx_valid_o (rx_valid_o),
        .frame_err_o(frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Drives one frame of master pins: half starts on the LRCLK edge, SCLK rises at 15 mod 32
    // and falls at 31 mod 32, SDout is read back where the master would sample it.
    task automatic applyStimulus(input logic [15:0] sdL, input logic [15:0] sdR, input int leftBits,
                                 input int dropBit, output logic [15:0] oTxL, output logic [15:0] oTxR,
                                 output int oTail, output int oLoads, output logic oDrop);
        int   leftLen, h, bitIdx;
        logic inRight;
        leftLen = leftBits * 32;
        oTxL = '0; oTxR = '0; oTail = 0; oLoads = 0; oDrop = 1'b0;
        for (int f = 0; f < leftLen + 512; f++) begin
            @(negedge clk);
            inRight = (f >= leftLen);
            h       = inRight ? f - leftLen : f;
            bitIdx  = h / 32;
            if ((h % 32 == 15) && (bitIdx < 16)) begin
                if (inRight) oTxR[15-bitIdx] = SDout_o;
                else         oTxL[15-bitIdx] = SDout_o;
            end
            if ((h == 505) && (SDout_o !== 1'b0)) oTail++;
            if (tx_load_o) oLoads++;
            LRCLK_i = !inRight;
            SCLK_i  = (h % 32 >= 15) && (h % 32 <= 30);
            SDin_i  = (bitIdx < 16) ? (inRight ? sdR[15-bitIdx] : sdL[15-bitIdx]) : 1'b0;
            if (!inRight && (f == 100)) rht_tx_i = ~rht_tx_i;
            if (inRight && (dropBit >= 0)) begin
                if (h == 32 * dropBit + 5)  RSTn_i = 1'b0;
                if (h == 32 * dropBit + 25) oDrop = SDout_o;
                if (h == 32 * dropBit + 37) RSTn_i = 1'b1;
            end
        end
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest pair still expected.
    always @(negedge clk) begin
        if (rx_valid_o) begin
            checkOutput("rxExpected", {63'd0, expQ.size() != 0}, 64'd1);
            if (expQ.size() != 0) checkOutput("rxPair", {32'd0, lft_rx_o, rht_rx_o}, {32'd0, expQ.pop_front()});
        end
    end

    initial begin
        tbl[0] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE};
        tbl[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        tbl[2] = '{16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A, 16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A};
        tbl[3] = '{16'h1234, 16'hA5C3, 16'hC3A5, 16'h0F0F, 16'h1234, 16'hA5C3, 16'hC3A5, 16'h0F0F};
        tbl[4] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE};

        rst_n = 1'b0; LRCLK_i = 1'b0; SCLK_i = 1'b0; MCLK_i = 1'b0; RSTn_i = 1'b0; SDin_i = 1'b0;
        lft_tx_i = '0; rht_tx_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetOuts", {28'd0, SDout_o, tx_load_o, rx_valid_o, frame_err_o, lft_rx_o, rht_rx_o}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        RSTn_i = 1'b1;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            lft_tx_i = tbl[i].lftTx;
            rht_tx_i = tbl[i].rhtTx;
            expQ.push_back({tbl[i].expRxL, tbl[i].expRxR});
            applyStimulus(tbl[i].sdL, tbl[i].sdR, 16, -1, txL, txR, tailBad, loads, dropSdout);
            checkOutput("txLeft", {48'd0, txL}, {48'd0, tbl[i].expTxL});
            checkOutput("txRight", {48'd0, txR}, {48'd0, tbl[i].expTxR});
            checkOutput("txTailZero", 64'(tailBad), 64'd0);
            checkOutput("txLoadOnce", 64'(loads), 64'd1);
        end
        checkOutput("frameErrClean", {63'd0, frame_err_o}, 64'd0);

        $display("[TB] short left half");
        lft_tx_i = 16'h3C3C; rht_tx_i = 16'h9669;
        applyStimulus(16'hDEAD, 16'hBEEF, 10, -1, txL, txR, tailBad, loads, dropSdout);
        checkOutput("shortFrameErr", {63'd0, frame_err_o}, 64'd1);
        checkOutput("shortTxRight", {48'd0, txR}, 64'h9669);
        lft_tx_i = 16'h0F0F; rht_tx_i = 16'hF0F0;
        expQ.push_back(32'h5AA5_C33C);
        applyStimulus(16'h5AA5, 16'hC33C, 16, -1, txL, txR, tailBad, loads, dropSdout);
        checkOutput("recoverTxLeft", {48'd0, txL}, 64'h0F0F);
        checkOutput("recoverTxRight", {48'd0, txR}, 64'hF0F0);
        lastPair = 32'h5AA5_C33C;

        $display("[TB] RSTn drop in right half");
        applyStimulus(16'h1111, 16'h2222, 16, 5, txL, txR, tailBad, loads, dropSdout);
        checkOutput("dropSdoutZero", {63'd0, dropSdout}, 64'd0);
        checkOutput("dropHoldPair", {32'd0, lft_rx_o, rht_rx_o}, {32'd0, lastPair});
        checkOutput("dropFrameErrKept", {63'd0, frame_err_o}, 64'd1);
        lft_tx_i = 16'h8421; rht_tx_i = 16'h1248;
        expQ.push_back(32'h6789_ABCD);
        applyStimulus(16'h6789, 16'hABCD, 16, -1, txL, txR, tailBad, loads, dropSdout);
        checkOutput("resumeTxLeft", {48'd0, txL}, 64'h8421);
        checkOutput("resumeTxRight", {48'd0, txR}, 64'h1248);

        $display("[TB] async reset mid-shift");
        fork
            applyStimulus(16'hFACE, 16'hCAFE, 16, -1, dumL, dumR, dumTail, dumLoads, dumDrop);
            begin
                repeat (300) @(negedge clk);
                rst_n  = 1'b0;
                RSTn_i = 1'b0;
                #1;
                checkOutput("asyncResetOuts",
                            {28'd0, SDout_o, tx_load_o, rx_valid_o, frame_err_o, lft_rx_o, rht_rx_o}, 64'd0);
            end
        join
        rst_n = 1'b1;
        lft_tx_i = 16'hFFFF; rht_tx_i = 16'hFFFF;
        applyStimulus(16'h7777, 16'h8888, 16, -1, txL, txR, tailBad, loads, dropSdout);
        checkOutput("holdWaitRstLoads", 64'(loads), 64'd0);
        checkOutput("holdWaitRstSdout", {32'd0, txL, txR}, 64'd0);
        RSTn_i = 1'b1;
        repeat (8) @(negedge clk);
        lft_tx_i = 16'h8001; rht_tx_i = 16'h7FFE;
        expQ.push_back(32'hA5C3_1234);
        applyStimulus(16'hA5C3, 16'h1234, 16, -1, txL, txR, tailBad, loads, dropSdout);
        checkOutput("postResetTx", {32'd0, txL, txR}, 64'h8001_7FFE);
        checkOutput("postResetFrameErr", {63'd0, frame_err_o}, 64'd0);

        repeat (4) @(negedge clk);
        checkOutput("rxPending", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
